mux10_scan_ctrl: RTL

//   Sequencer that sits directly upstream of the 10:1 mux tree: drives its 4-bit binary

---
 rtl/mux10_scan_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mux10_scan_ctrl.sv
// Scan sequencer for a 10:1 mux tree: steps the select over the enabled channels,
// waits SETTLE cycles per channel, samples mux_y and delivers a frame over valid/ready.
module mux10_scan_ctrl #(
   parameter int NUM_CH = 10,
   parameter int SEL_W  = 4,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              continuous,
   input  logic [NUM_CH-1:0] chan_mask,
   output logic [SEL_W-1:0]  sel,
   input  logic              mux_y,
   output logic [NUM_CH-1:0] frame_data,
   output logic [NUM_CH-1:0] frame_mask,
   output logic              frame_valid,
   input  logic              frame_ready,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [NUM_CH-1:0]   data_q, data_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                launch_s;
   logic [SEL_W:0]      first_s;
   logic [SEL_W:0]      next_s;

   // Lowest enabled channel index >= from; MSB of the result flags that one exists.
   function automatic logic [SEL_W:0] find_from(input logic [NUM_CH-1:0] m, input int from);
      logic [SEL_W:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         r = (m[i] && (i >= from)) ? {1'b1, SEL_W'(i)} : r;
      end
      return r;
   endfunction

   // Next-state and next-output computation for the scan FSM.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      mask_d   = mask_q;
      valid_d  = valid_q;
      launch_s = 1'b0;
      first_s  = find_from(chan_mask, 0);
      next_s   = find_from(mask_q, int'(sel_q) + 1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               launch_s = 1'b1;
            end else begin
               launch_s = 1'b0;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               data_d[sel_q] = mux_y;
               if (next_s[SEL_W]) begin
                  sel_d = next_s[SEL_W-1:0];
                  cnt_d = SETTLE_C;
               end else begin
                  valid_d = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (valid_q && frame_ready) begin
               valid_d = 1'b0;
               if (continuous) begin
                  launch_s = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               valid_d = valid_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase

      // Scan start is shared by IDLE start and the continuous rescan after a handshake.
      if (launch_s) begin
         mask_d = chan_mask;
         data_d = '0;
         if (first_s[SEL_W]) begin
            sel_d   = first_s[SEL_W-1:0];
            cnt_d   = SETTLE_C;
            state_d = S_WAIT;
         end else begin
            valid_d = 1'b1;
            state_d = S_DONE;
         end
      end else begin
         mask_d = mask_d;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         cnt_q   <= 4'd0;
         data_q  <= '0;
         mask_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign sel         = sel_q;
   assign frame_data  = data_q;
   assign frame_mask  = mask_q;
   assign frame_valid = valid_q;
   assign busy        = busy_q;

endmodule
